// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA path. It samples hs/vs and the {r,g,b} bus,
// recovers line and frame timing, measures clocks per line and lines per frame,
// locks onto a stable mode, and then re-emits the active pixels with x/y coordinates.
module vga_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic [2:0]  r,
  input  logic [2:0]  g,
  input  logic [1:0]  b,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] h_total,
  output logic [10:0] v_total
);

  localparam logic [11:0] H_LO      = 12'(H_BP);
  localparam logic [11:0] H_HI      = 12'(H_BP + H_ACTIVE);
  localparam logic [10:0] V_LO      = 11'(V_BP);
  localparam logic [10:0] V_HI      = 11'(V_BP + V_ACTIVE);
  localparam logic        SYNC_IDLE = !SYNC_POL;

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
  state_t state_q, state_d;

  logic        s_hs_q, s_vs_q, p_hs_q, p_vs_q;
  logic [7:0]  s_pix_q, d_pix_q;
  logic [11:0] hcnt_q, line_len_q, h_total_q;
  logic [10:0] vcnt_q, v_total_q;
  logic        hs_te, vs_te, h_sat, v_sat, store, in_active;
  logic [11:0] line_len_new, line_len_cur;
  logic [10:0] v_meas;
  logic        pix_valid_d, pix_valid_q, frame_start_d, frame_start_q;
  logic        locked_d, locked_q;
  logic [7:0]  pix_data_d, pix_data_q;
  logic [9:0]  pix_x_d, pix_x_q;
  logic [8:0]  pix_y_d, pix_y_q;

  assign hs_te        = (p_hs_q == SYNC_POL) && (s_hs_q == SYNC_IDLE);
  assign vs_te        = (p_vs_q == SYNC_POL) && (s_vs_q == SYNC_IDLE);
  assign h_sat        = (hcnt_q == '1);
  assign v_sat        = (vcnt_q == '1);
  assign line_len_new = hcnt_q + 12'd1;
  assign line_len_cur = hs_te ? line_len_new : line_len_q;
  assign v_meas       = vcnt_q + 11'd1;
  assign in_active    = (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
                        (vcnt_q >= V_LO) && (vcnt_q < V_HI);

  // Input registers; pixel data is delayed one extra stage so that the sample
  // sitting in d_pix_q belongs to column hcnt_q (hcnt restarts one cycle after the edge).
  // Syncs reset to their idle level so reset release is never taken for a trailing edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_hs_q  <= SYNC_IDLE;
      s_vs_q  <= SYNC_IDLE;
      p_hs_q  <= SYNC_IDLE;
      p_vs_q  <= SYNC_IDLE;
      s_pix_q <= '0;
      d_pix_q <= '0;
    end else begin
      s_hs_q  <= hs;
      s_vs_q  <= vs;
      p_hs_q  <= s_hs_q;
      p_vs_q  <= s_vs_q;
      s_pix_q <= {r, g, b};
      d_pix_q <= s_pix_q;
    end
  end

  // Horizontal/vertical position counters and the length of the last full line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      line_len_q <= '0;
    end else begin
      if (hs_te)       hcnt_q <= '0;
      else if (!h_sat) hcnt_q <= hcnt_q + 12'd1;
      if (vs_te)                 vcnt_q <= '0;
      else if (hs_te && !v_sat)  vcnt_q <= vcnt_q + 11'd1;
      if (hs_te) line_len_q <= line_len_new;
    end
  end

  // State register plus the stored mode measurements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      h_total_q <= '0;
      v_total_q <= '0;
    end else begin
      state_q <= state_d;
      if (store) begin
        h_total_q <= line_len_cur;
        v_total_q <= v_meas;
      end
    end
  end

  // Lock sequencing: advance on vs trailing edges, drop on any timing disagreement.
  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    if (h_sat || v_sat) begin
      state_d = SEARCH;
    end else begin
      unique case (state_q)
        SEARCH:  if (vs_te) state_d = MEASURE;
        MEASURE: if (vs_te) begin
          store   = 1'b1;
          state_d = VERIFY;
        end
        VERIFY:  if (vs_te) begin
          if (line_len_cur == h_total_q && v_meas == v_total_q) state_d = LOCKED;
          else store = 1'b1;
        end
        LOCKED: begin
          if (hs_te && line_len_new != h_total_q) begin
            state_d = SEARCH;
          end else if (vs_te && v_meas != v_total_q) begin
            store   = 1'b1;
            state_d = VERIFY;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Output next-values; keyed on the next state so pix_valid and locked fall together.
  always_comb begin
    locked_d      = (state_d == LOCKED);
    pix_valid_d   = in_active && locked_d;
    pix_data_d    = pix_valid_d ? d_pix_q : pix_data_q;
    pix_x_d       = pix_valid_d ? 10'(hcnt_q - H_LO) : pix_x_q;
    pix_y_d       = pix_valid_d ? 9'(vcnt_q - V_LO) : pix_y_q;
    frame_start_d = pix_valid_d && (pix_x_d == '0) && (pix_y_d == '0);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture: a reduced video mode driven with random pixel data,
// an event-level reference model producing expected lock state and pixels, and a
// monitor that pops and compares whenever the capture block presents output.
module tb_vga_capture;

  localparam int HA   = 16;
  localparam int HB   = 4;
  localparam int VA   = 6;
  localparam int VB   = 3;
  localparam int HS_W = 6;
  localparam int VS_W = 2;
  localparam int HT   = HB + HA + 4 + HS_W;     // 30 clocks per line
  localparam int VT   = VS_W + VB + VA + 3;     // 14 lines per frame

  logic        clk = 1'b1;
  logic        rst_n, hs, vs;
  logic [2:0]  r, g;
  logic [1:0]  b;
  logic        pix_valid, frame_start, locked;
  logic [7:0]  pix_data;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] h_total;
  logic [10:0] v_total;

  vga_capture #(.H_ACTIVE(HA), .H_BP(HB), .V_ACTIVE(VA), .V_BP(VB), .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .locked(locked), .h_total(h_total), .v_total(v_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       x;
    int       y;
    int       d;
    int       fs;
    int       when;
  } pix_t;

  typedef enum int {M_SEARCH, M_MEASURE, M_VERIFY, M_LOCKED} mst_t;

  pix_t pq[$];
  bit   lockq[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  // reference model state, advanced once per input sample
  mst_t mst = M_SEARCH;
  int   mh = 0, mv = 0, last_t = 0, vl = 0, llen = 0;
  bit   prev_h = 1'b1, prev_v = 1'b1, pend = 1'b0;
  pix_t pend_pix;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Sample t is taken at clock edge t; the resulting lock state shows on locked after edge t+1.
  task automatic model_sample(input int t, input bit h, input bit v, input int d, input bit rn);
    bit hte, vte, sat;
    int lnew, lcur, vm, k;
    if (!rn) begin
      mst = M_SEARCH; mh = 0; mv = 0; last_t = t - 1; vl = 0; llen = 0;
      prev_h = 1'b1; prev_v = 1'b1; pend = 1'b0;
      if (lockq.size() > 0) lockq[lockq.size()-1] = 1'b0;
      lockq.push_back(1'b0);
      return;
    end
    hte = !prev_h && h;
    vte = !prev_v && v;
    prev_h = h;
    prev_v = v;
    sat  = (t - last_t) >= 4096;
    lnew = t - last_t;
    lcur = hte ? lnew : llen;
    vm   = vl + 1;
    if (sat) mst = M_SEARCH;
    else case (mst)
      M_SEARCH:  if (vte) mst = M_MEASURE;
      M_MEASURE: if (vte) begin mh = lcur; mv = vm; mst = M_VERIFY; end
      M_VERIFY:  if (vte) begin
        if (lcur == mh && vm == mv) mst = M_LOCKED;
        else begin mh = lcur; mv = vm; end
      end
      M_LOCKED: begin
        if (hte && lnew != mh) mst = M_SEARCH;
        else if (vte && vm != mv) begin mh = lcur; mv = vm; mst = M_VERIFY; end
      end
      default: mst = M_SEARCH;
    endcase
    if (hte) begin llen = lnew; last_t = t; end
    if (vte) vl = 0;
    else if (hte) vl++;
    if (pend) begin
      if (mst == M_LOCKED) pq.push_back(pend_pix);
      pend = 1'b0;
    end
    k = t - last_t;
    if (k >= HB && k < HB + HA && vl >= VB && vl < VB + VA) begin
      pend = 1'b1;
      pend_pix.x = k - HB;
      pend_pix.y = vl - VB;
      pend_pix.d = d;
      pend_pix.fs = (k == HB && vl == VB) ? 1 : 0;
      pend_pix.when = t + 2;
    end
    lockq.push_back(mst == M_LOCKED);
  endtask

  task automatic drive(input bit h, input bit v, input int d, input bit rn);
    logic [7:0] dv;
    @(negedge clk);
    dv = 8'(d);
    hs = h; vs = v; {r, g, b} = dv; rst_n = rn;
    model_sample(edge_cnt + 1, h, v, int'(dv), rn);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_valid"},   int'(pix_valid),   0);
    chk({tag, "_pix_data"},    int'(pix_data),    0);
    chk({tag, "_pix_x"},       int'(pix_x),       0);
    chk({tag, "_pix_y"},       int'(pix_y),       0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_locked"},      int'(locked),      0);
    chk({tag, "_h_total"},     int'(h_total),     0);
    chk({tag, "_v_total"},     int'(v_total),     0);
  endtask

  // One frame; lines begin at the hs trailing edge, vs changes coincide with it.
  task automatic frame(input int nl, input int short_l, input int rst_l, input int rst_h);
    int len;
    bit rn;
    for (int l = 0; l < nl; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        rn = !(l == rst_l && h == rst_h);
        drive(h < len - HS_W, l < nl - VS_W, int'($urandom_range(255)), rn);
        if (!rn) begin
          @(posedge clk); #1;
          chk_zero("midreset");
        end
      end
    end
  endtask

  task automatic preamble();
    repeat (3) drive(1'b0, 1'b0, 0, 1'b1);
  endtask

  // monitor: lock state every cycle, pixels whenever pix_valid is presented
  initial begin
    pix_t p;
    bit   el;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (lockq.size() >= 2) begin
        el = lockq.pop_front();
        chk("locked", int'(locked), int'(el));
      end
      if (pix_valid) begin
        if (pq.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          p = pq.pop_front();
          chk("pix_time", edge_cnt, p.when);
          chk("pix_x", int'(pix_x), p.x);
          chk("pix_y", int'(pix_y), p.y);
          chk("pix_data", int'(pix_data), p.d);
          chk("frame_start", int'(frame_start), p.fs);
        end
      end else begin
        if (pq.size() > 0 && pq[0].when <= edge_cnt) begin
          p = pq.pop_front();
          chk("missing_pixel_x", -1, p.x);
        end
        chk("frame_start_idle", int'(frame_start), 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
    repeat (3) drive(1'b1, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    chk_zero("reset");

    // standard stream: locks on the 3rd vs trailing edge
    preamble();
    repeat (4) frame(VT, -1, -1, -1);
    chk("std_h_total", int'(h_total), HT);
    chk("std_v_total", int'(v_total), VT);
    chk("std_locked", int'(locked), 1);

    // one short line, then relock
    frame(VT, 8, -1, -1);
    chk("short_locked", int'(locked), 0);
    repeat (4) frame(VT, -1, -1, -1);
    chk("short_relock", int'(locked), 1);
    chk("short_h_total", int'(h_total), HT);

    // frame height grows by one line
    frame(VT + 1, -1, -1, -1);
    frame(VT + 1, -1, -1, -1);
    chk("vchg_locked", int'(locked), 0);
    chk("vchg_v_total", int'(v_total), VT + 1);
    frame(VT + 1, -1, -1, -1);
    chk("vchg_relock", int'(locked), 1);
    repeat (3) frame(VT, -1, -1, -1);
    chk("vback_v_total", int'(v_total), VT);
    chk("vback_locked", int'(locked), 1);

    // hs idle long enough to saturate the line counter
    repeat (5000) drive(1'b1, 1'b1, int'($urandom_range(255)), 1'b1);
    chk("idle_locked", int'(locked), 0);
    chk("idle_pix_valid", int'(pix_valid), 0);
    preamble();
    repeat (5) frame(VT, -1, -1, -1);
    chk("idle_relock", int'(locked), 1);

    // one-cycle reset in the middle of a locked frame
    frame(VT, -1, 5, 25);
    repeat (4) frame(VT, -1, -1, -1);
    chk("rst_relock", int'(locked), 1);
    chk("rst_h_total", int'(h_total), HT);
    chk("rst_v_total", int'(v_total), VT);

    repeat (10) drive(1'b1, 1'b1, 0, 1'b1);
    @(posedge clk); #2;
    chk("pixels_left", pq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
